// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types and constants
package ps2_pkg;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int PS2_EVT_W = 10;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
// A write while full is accepted only when a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver with scan-code decoder
// Pad lines are synchronized and debounced; frames are decoded into {ext, brk, code} events.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 rd_en,
  output logic [PS2_EVT_W-1:0] rd_data,
  output logic                 empty,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int FW     = $clog2(FILTER_LEN + 1);

  // bit 0 carries the clock line, bit 1 the data line
  logic [1:0]      r_s1;
  logic [1:0]      r_s2;
  logic [1:0]      r_filt;
  logic [FW-1:0]   r_fcnt [2];
  logic            r_clk_prev;

  ps2_state_t      r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext;
  logic            r_brk;
  logic            r_frame_err;
  logic            r_overflow;

  logic            w_fall;
  logic            w_dat;
  logic            w_timeout;
  logic            w_frame_ok;
  logic            w_push;
  logic            w_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1       <= 2'b11;
      r_s2       <= 2'b11;
      r_filt     <= 2'b11;
      r_clk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_s1       <= {ps2_data, ps2_clk};
      r_s2       <= r_s1;
      r_clk_prev <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign w_fall     = r_clk_prev && !r_filt[0];
  assign w_dat      = r_filt[1];
  assign w_timeout  = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_W'(TO_CYC));
  assign w_frame_ok = w_dat && (^{r_par, r_shift});
  assign w_push     = w_fall && (r_state == ST_STOP) && w_frame_ok &&
                      (r_shift != PS2_EXT) && (r_shift != PS2_BRK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_state == ST_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_ext       <= 1'b0;
        r_brk       <= 1'b0;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_dat) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= w_dat;
            r_state <= ST_STOP;
          end
          default: begin
            r_state <= ST_IDLE;
            if (w_frame_ok && r_shift == PS2_EXT) begin
              r_ext <= 1'b1;
            end else if (w_frame_ok && r_shift == PS2_BRK) begin
              r_brk <= 1'b1;
            end else begin
              r_frame_err <= !w_frame_ok;
              r_ext       <= 1'b0;
              r_brk       <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_overflow <= 1'b0;
    else if (w_push && w_full && !rd_en) r_overflow <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data ({r_ext, r_brk, r_shift}),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (w_full)
  );

  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule
